// File: rtl/ghazi_uart_pkg.sv
// Shared types and constants for the autobaud UART receiver.
package ghazi_uart_pkg;

  typedef enum logic [2:0] {
    StLockWait,
    StMeasure,
    StSyncStop,
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h55;

  // Falling edges seen on the line while a framed byte is sent:
  // the idle-to-start edge plus every 1->0 step between data bits.
  function automatic int unsigned sync_falls(logic [7:0] b);
    int unsigned n = 1;
    for (int i = 1; i < 8; i++) begin
      if (b[i-1] && !b[i]) n++;
    end
    return n;
  endfunction

  localparam int unsigned SYNC_FALL_EDGES = sync_falls(SYNC_BYTE);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw line through two flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_autobaud_rx.sv
// UART 8N1 receiver that measures its bit period from a 0x55 sync byte,
// with a fixed-divisor override.
module uart_autobaud_rx
  import ghazi_uart_pkg::*;
#(
  parameter int unsigned MIN_CPB = 16,
  parameter int unsigned CPB_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  input  logic             relock_i,
  input  logic             use_override_i,
  input  logic [CPB_W-1:0] clks_per_bit_i,
  output logic             rx_dv_o,
  output logic [7:0]       rx_byte_o,
  output logic             frame_err_o,
  output logic             baud_locked_o,
  output logic [CPB_W-1:0] clks_per_bit_o
);

  localparam int unsigned MW = CPB_W + 3;
  // Eight bit times of the largest representable divisor.
  localparam logic [MW-1:0] MEAS_LIMIT = {{CPB_W{1'b1}}, 3'b000};
  localparam logic [2:0] LAST_EDGE = 3'(SYNC_FALL_EDGES - 2);

  logic rxs, rxs_q;
  logic fall, edge_any;

  rx_state_e        state_q, state_d;
  logic [MW-1:0]    cnt_q, cnt_d;
  logic [2:0]       edge_cnt_q, edge_cnt_d;
  logic [CPB_W-1:0] phase_q, phase_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [CPB_W-1:0] cpb_meas_q, cpb_meas_d;
  logic [CPB_W-1:0] cpb_frame_q, cpb_frame_d;
  logic             locked_q, locked_d;
  logic             lock_ovr_q, lock_ovr_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_dv_q, rx_dv_d;
  logic             frame_err_q, frame_err_d;

  logic [CPB_W-1:0] cpb_eff;
  logic [MW-1:0]    cpb_sum;
  logic             phase_end;

  uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rxs)
  );

  assign fall      = rxs_q & ~rxs;
  assign edge_any  = rxs_q ^ rxs;
  assign cpb_eff   = use_override_i ? clks_per_bit_i : cpb_meas_q;
  // Rounded divisor from eight measured bit times.
  assign cpb_sum   = (cnt_q + MW'(5)) >> 3;
  // Widened compare so a zero divisor cannot wrap.
  assign phase_end = ({1'b0, phase_q} + (CPB_W + 1)'(1)) >= {1'b0, cpb_frame_q};

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxs_q       <= 1'b1;
      state_q     <= StLockWait;
      cnt_q       <= '0;
      edge_cnt_q  <= '0;
      phase_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      cpb_meas_q  <= '0;
      cpb_frame_q <= '0;
      locked_q    <= 1'b0;
      lock_ovr_q  <= 1'b0;
      rx_byte_q   <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rxs_q       <= rxs;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      cpb_meas_q  <= cpb_meas_d;
      cpb_frame_q <= cpb_frame_d;
      locked_q    <= locked_d;
      lock_ovr_q  <= lock_ovr_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: measurement, framing and strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_cnt_d  = edge_cnt_q;
    phase_d     = phase_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    cpb_meas_d  = cpb_meas_q;
    cpb_frame_d = cpb_frame_q;
    locked_d    = locked_q;
    lock_ovr_d  = lock_ovr_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StLockWait: begin
        if (use_override_i) begin
          state_d    = StIdle;
          locked_d   = 1'b1;
          lock_ovr_d = 1'b1;
        end else if (fall) begin
          state_d    = StMeasure;
          cnt_d      = '0;
          edge_cnt_d = '0;
          phase_d    = '0;
        end
      end
      StMeasure: begin
        cnt_d   = cnt_q + MW'(1);
        // phase_q doubles as the no-edge timeout here.
        phase_d = edge_any ? '0 : phase_q + CPB_W'(1);
        if (cnt_q >= MEAS_LIMIT || phase_q == '1) begin
          state_d = StLockWait;
        end else if (fall) begin
          if (edge_cnt_q == LAST_EDGE) begin
            if (cpb_sum < MW'(MIN_CPB)) begin
              state_d = StLockWait;
            end else begin
              cpb_meas_d  = cpb_sum[CPB_W-1:0];
              cpb_frame_d = cpb_sum[CPB_W-1:0];
              phase_d     = '0;
              state_d     = StSyncStop;
            end
          end else begin
            edge_cnt_d = edge_cnt_q + 3'd1;
          end
        end
      end
      StSyncStop: begin
        if (!rxs) begin
          phase_d = '0;
        end else if (phase_end) begin
          state_d    = StIdle;
          locked_d   = 1'b1;
          lock_ovr_d = 1'b0;
        end else begin
          phase_d = phase_q + CPB_W'(1);
        end
      end
      StIdle: begin
        if (use_override_i) lock_ovr_d = 1'b1;
        if (lock_ovr_q && !use_override_i) begin
          state_d    = StLockWait;
          locked_d   = 1'b0;
          lock_ovr_d = 1'b0;
        end else if (!rxs) begin
          state_d     = StStart;
          phase_d     = '0;
          cpb_frame_d = cpb_eff;
        end
      end
      StStart: begin
        if (phase_q == (cpb_frame_q >> 1)) begin
          phase_d   = '0;
          bit_idx_d = '0;
          state_d   = rxs ? StIdle : StData;
        end else begin
          phase_d = phase_q + CPB_W'(1);
        end
      end
      StData: begin
        if (phase_end) begin
          shift_d   = {rxs, shift_q[7:1]};
          phase_d   = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          phase_d = phase_q + CPB_W'(1);
        end
      end
      StStop: begin
        if (phase_end) begin
          if (rxs) begin
            rx_byte_d = shift_q;
            rx_dv_d   = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          phase_d = phase_q + CPB_W'(1);
        end
      end
      StBreak: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StLockWait;
    endcase

    // Relock wins over everything and silently drops a frame in flight.
    if (relock_i && !use_override_i) begin
      state_d     = StLockWait;
      locked_d    = 1'b0;
      lock_ovr_d  = 1'b0;
      rx_dv_d     = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  assign rx_dv_o        = rx_dv_q;
  assign rx_byte_o      = rx_byte_q;
  assign frame_err_o    = frame_err_q;
  assign baud_locked_o  = locked_q;
  assign clks_per_bit_o = locked_q ? cpb_eff : '0;

endmodule

// File: tb/tb_uart_autobaud_rx.sv
// Directed bench for uart_autobaud_rx with a frame-level expected-event model.
module tb_uart_autobaud_rx;
  import ghazi_uart_pkg::*;

  localparam int unsigned CPB_W   = 16;
  localparam int unsigned MIN_CPB = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             rx_i;
  logic             relock_i;
  logic             use_override_i;
  logic [CPB_W-1:0] clks_per_bit_i;
  logic             rx_dv_o;
  logic [7:0]       rx_byte_o;
  logic             frame_err_o;
  logic             baud_locked_o;
  logic [CPB_W-1:0] clks_per_bit_o;

  int checks = 0;
  int errors = 0;

  // Model: expected strobes in order (1 = framing error), plus lock state.
  bit         exp_ferr[$];
  logic [7:0] exp_data[$];
  logic [7:0] last_byte;
  bit         model_locked;
  int         model_cpb;

  always #5 clk_i = ~clk_i;

  uart_autobaud_rx #(
    .MIN_CPB (MIN_CPB),
    .CPB_W   (CPB_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .rx_i           (rx_i),
    .relock_i       (relock_i),
    .use_override_i (use_override_i),
    .clks_per_bit_i (clks_per_bit_i),
    .rx_dv_o        (rx_dv_o),
    .rx_byte_o      (rx_byte_o),
    .frame_err_o    (frame_err_o),
    .baud_locked_o  (baud_locked_o),
    .clks_per_bit_o (clks_per_bit_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_lock(input string name);
    chk({name, " locked"}, 32'(baud_locked_o), 32'(model_locked));
    chk({name, " cpb"}, 32'(clks_per_bit_o), model_locked ? 32'(model_cpb) : 32'd0);
  endtask

  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] b, input int c, input logic stop_v,
                            input int stop_n);
    hold(1'b0, c);
    for (int i = 0; i < 8; i++) hold(b[i], c);
    hold(stop_v, stop_n);
  endtask

  task automatic send_data(input logic [7:0] b, input int c);
    if (model_locked) begin
      exp_ferr.push_back(1'b0);
      exp_data.push_back(b);
    end
    send_frame(b, c, 1'b1, c);
  endtask

  // Sync byte: eight bit times span its five falling edges; rounded divisor.
  task automatic send_sync(input int c);
    int m;
    send_frame(SYNC_BYTE, c, 1'b1, c);
    hold(1'b1, c);
    m = (8 * c + 4) / 8;
    if (m >= int'(MIN_CPB)) begin
      model_locked = 1'b1;
      model_cpb    = m;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_data.size() != 0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, " pending strobes"}, 32'(exp_data.size()), 32'd0);
    exp_ferr.delete();
    exp_data.delete();
  endtask

  // Every strobe must match the head of the expected queue.
  task automatic monitor();
    bit         f;
    logic [7:0] d;
    forever begin
      @(negedge clk_i);
      if (rst_ni && (rx_dv_o || frame_err_o)) begin
        if (rx_dv_o && frame_err_o) begin
          chk("dv and ferr together", 32'd1, 32'd0);
        end else if (exp_data.size() == 0) begin
          chk("unexpected strobe byte", 32'(rx_byte_o), 32'hFFFF_FFFF);
        end else begin
          f = exp_ferr.pop_front();
          d = exp_data.pop_front();
          chk("strobe kind ferr", 32'(frame_err_o), 32'(f));
          if (f) begin
            chk("byte held on ferr", 32'(rx_byte_o), 32'(last_byte));
          end else begin
            chk("rx_byte", 32'(rx_byte_o), 32'(d));
            last_byte = d;
          end
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni         = 1'b0;
    rx_i           = 1'b1;
    relock_i       = 1'b0;
    use_override_i = 1'b0;
    clks_per_bit_i = '0;
    last_byte      = 8'h00;
    model_locked   = 1'b0;
    model_cpb      = 0;
    fork
      monitor();
    join_none

    // Reset with line activity.
    repeat (3) begin
      @(negedge clk_i) rx_i = 1'b0;
      @(negedge clk_i) rx_i = 1'b1;
    end
    chk("reset rx_dv", 32'(rx_dv_o), 32'd0);
    chk("reset frame_err", 32'(frame_err_o), 32'd0);
    chk("reset rx_byte", 32'(rx_byte_o), 32'd0);
    chk_lock("reset");
    @(negedge clk_i) rst_ni = 1'b1;
    hold(1'b1, 20);

    // Autobaud at 348 then a data byte.
    send_sync(348);
    chk_lock("autobaud");
    chk("autobaud cpb literal", 32'(clks_per_bit_o), 32'd348);
    send_data(8'hA5, 348);
    drain("A5", 700);
    chk("A5 literal", 32'(rx_byte_o), 32'hA5);

    // Low stop bit held long, then a clean byte.
    exp_ferr.push_back(1'b1);
    exp_data.push_back(8'h00);
    send_frame(8'h12, 348, 1'b0, 1000);
    hold(1'b1, 400);
    drain("ferr", 700);
    send_data(8'h34, 348);
    drain("34", 700);
    chk("34 literal", 32'(rx_byte_o), 32'h34);

    // Short low glitch is not a start bit.
    hold(1'b0, 100);
    hold(1'b1, 1000);
    chk("glitch byte held", 32'(rx_byte_o), 32'h34);
    chk_lock("glitch");

    // Fixed divisor override.
    use_override_i = 1'b1;
    clks_per_bit_i = 16'd16;
    model_locked   = 1'b1;
    model_cpb      = 16;
    hold(1'b1, 10);
    chk_lock("override");
    send_data(8'h3C, 16);
    drain("3C", 64);
    chk("3C literal", 32'(rx_byte_o), 32'h3C);
    use_override_i = 1'b0;
    model_locked   = 1'b0;
    hold(1'b1, 10);
    chk_lock("override off");

    // Too-fast sync must be rejected.
    send_sync(8);
    chk_lock("reject");
    chk("reject locked literal", 32'(baud_locked_o), 32'd0);

    // Lock at 200, relock mid-frame, re-measure at 100.
    send_sync(200);
    chk_lock("lock200");
    hold(1'b0, 200);
    hold(1'b1, 200);
    hold(1'b0, 100);
    relock_i = 1'b1;
    @(negedge clk_i);
    relock_i     = 1'b0;
    model_locked = 1'b0;
    chk_lock("relock");
    hold(1'b1, 1000);
    send_sync(100);
    chk_lock("lock100");
    chk("lock100 cpb literal", 32'(clks_per_bit_o), 32'd100);
    send_data(8'h77, 100);
    drain("77", 200);
    chk("77 literal", 32'(rx_byte_o), 32'h77);

    // Reset in the middle of a byte.
    hold(1'b0, 100);
    hold(1'b1, 100);
    hold(1'b0, 50);
    rst_ni       = 1'b0;
    model_locked = 1'b0;
    last_byte    = 8'h00;
    hold(1'b0, 5);
    chk("midreset rx_byte", 32'(rx_byte_o), 32'd0);
    chk_lock("midreset");
    rx_i = 1'b1;
    @(negedge clk_i) rst_ni = 1'b1;
    hold(1'b1, 2000);
    chk("post reset rx_byte", 32'(rx_byte_o), 32'd0);
    chk_lock("post reset");
    drain("final", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
